// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule producer: loads one 512-bit block and streams W0..W(NUM_ROUNDS-1)
// through a 16-word sliding window, one word per accepted beat.
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [511:0] in_block_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_word_o,
  output logic [5:0]   out_idx_o,
  output logic         out_last_o,
  output logic         busy_o
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [31:0] win_q [16];
  logic [5:0]  idx_q;
  logic        last_q;
  logic [31:0] w_new_d;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign w_new_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            for (int i = 0; i < 16; i++) win_q[i] <= in_block_i[511 - 32*i -: 32];
            idx_q   <= '0;
            last_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // The window and index only move on a beat, so out_word stays stable under backpressure.
          if (out_ready_i) begin
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= w_new_d;
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              idx_q   <= '0;
              last_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 6'd1;
              last_q  <= (idx_q + 6'd1) == LAST_IDX;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == RUN);
  assign busy_o      = (state_q == RUN);
  assign out_word_o  = win_q[0];
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed and randomized bench for sha256_msg_schedule against a software schedule model.
module tb_sha256_msg_schedule;

  localparam int NR = 64;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [511:0] in_block_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  out_word_o;
  logic [5:0]   out_idx_o;
  logic         out_last_o;
  logic         busy_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] mw    [64];
  logic [31:0] got_w [64];

  sha256_msg_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_block_i  (in_block_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_word_o  (out_word_o),
    .out_idx_o   (out_idx_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) mw[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3);
      s1 = rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10);
      mw[t] = s1 + mw[t-7] + s0 + mw[t-16];
    end
  endtask

  // Presents a block and returns at the negedge just after it was accepted.
  task automatic load(input logic [511:0] b);
    int guard = 0;
    @(negedge clk_i);
    in_block_i = b;
    in_valid_i = 1'b1;
    while (!in_ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 200) check("load_timeout", 64'd0, 64'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  // mode 0: always ready; 1: random with 10-cycle stalls at idx 15 and 63; 2: ready 7/8.
  task automatic stream(input logic [511:0] b, input int mode, input int stop, input string tag);
    int beats = 0;
    int cyc = 0;
    int stall_left = 0;
    bit done15 = 0, done63 = 0, stalled = 0;
    logic r;
    logic [31:0] pw;
    logic [5:0]  pi;
    build_model(b);
    while (beats < stop && cyc < 2000) begin
      check({tag, "_valid"}, out_valid_o, 1);
      check({tag, "_in_ready_run"}, in_ready_o, 0);
      check({tag, "_busy"}, busy_o, 1);
      if (stalled) begin
        check({tag, "_hold_word"}, out_word_o, pw);
        check({tag, "_hold_idx"}, out_idx_o, pi);
      end
      if (mode == 1 && beats == 15 && !done15) begin done15 = 1; stall_left = 10; end
      if (mode == 1 && beats == 63 && !done63) begin done63 = 1; stall_left = 10; end
      if (mode == 0) r = 1'b1;
      else if (stall_left > 0) begin r = 1'b0; stall_left--; end
      else if (mode == 1) r = 1'($urandom_range(0, 1));
      else r = ($urandom_range(0, 7) != 0);
      out_ready_i = r;
      if (r) begin
        check({tag, "_word"}, out_word_o, mw[beats]);
        check({tag, "_idx"}, out_idx_o, 64'(beats));
        check({tag, "_last"}, out_last_o, 64'(beats == NR - 1));
        got_w[beats] = out_word_o;
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        pw = out_word_o;
        pi = out_idx_o;
      end
      @(negedge clk_i);
      cyc++;
    end
    out_ready_i = 1'b0;
    if (beats < stop) check({tag, "_timeout_beats"}, 64'(beats), 64'(stop));
    if (stop == NR) begin
      check({tag, "_end_valid"}, out_valid_o, 0);
      check({tag, "_end_in_ready"}, in_ready_o, 1);
      check({tag, "_end_busy"}, busy_o, 0);
      check({tag, "_end_last"}, out_last_o, 0);
      check({tag, "_end_idx"}, out_idx_o, 0);
    end
  endtask

  logic [511:0] abc_blk, zero_blk, ones_blk, alt_blk, rnd_blk;

  initial begin
    abc_blk  = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    zero_blk = '0;
    ones_blk = '1;
    alt_blk  = {16{32'hA5A5_0F0F}};

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_block_i  = '0;
    out_ready_i = 1'b0;
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_idx", out_idx_o, 0);
    check("rst_last", out_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_word", out_word_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    load(abc_blk);
    stream(abc_blk, 0, NR, "abc");
    check("abc_w0", got_w[0], 32'h61626380);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);

    load(zero_blk);
    stream(zero_blk, 0, NR, "zero");

    load(abc_blk);
    stream(abc_blk, 1, NR, "bp");

    load(abc_blk);
    in_valid_i = 1'b1;
    in_block_i = alt_blk;
    stream(abc_blk, 0, NR, "hold_first");
    @(negedge clk_i);
    in_valid_i = 1'b0;
    stream(alt_blk, 0, NR, "hold_second");

    load(abc_blk);
    stream(abc_blk, 2, 30, "pre_rst");
    check("idx_pre_rst", out_idx_o, 30);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_in_ready", in_ready_o, 1);
    check("mid_rst_idx", out_idx_o, 0);
    check("mid_rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      check("post_rst_no_word", out_valid_o, 0);
    end
    out_ready_i = 1'b0;
    load(ones_blk);
    stream(ones_blk, 0, NR, "ones");

    for (int k = 0; k < 1000; k++) begin
      for (int j = 0; j < 16; j++) rnd_blk[511 - 32*j -: 32] = $urandom;
      load(rnd_blk);
      stream(rnd_blk, 2, NR, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Producer side of the SHA-256 compression datapath. Accepts one 512-bit padded message block and streams the 64 schedule words W0..W63 to the round engine, one word per accepted beat. Uses a 16-word sliding window and the small-sigma functions. Valid/ready handshake on both sides, with backpressure from the round engine.

Parameters:
NUM_ROUNDS, 64, number of schedule words emitted per block (legal range 16..64; 64 for SHA-256).

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_block is valid.
in_ready  output  1  block can be accepted.
in_block  input  512  message block; W0 = in_block[511:480], W15 = in_block[31:0] (big-endian word order).
out_valid  output  1  out_word is valid.
out_ready  input  1  round engine accepts out_word.
out_word  output  32  schedule word W[out_idx].
out_idx  output  6  round index t of out_word, 0..NUM_ROUNDS-1.
out_last  output  1  high with out_valid when out_idx == NUM_ROUNDS-1.
busy  output  1  high while in RUN state.

Behaviour:
- Reset (async assert, sync-deassert by the system): state=IDLE, window cleared to 0, out_valid=0, out_idx=0, out_last=0, busy=0, in_ready=1, out_word=0.
- States: IDLE, RUN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, load win[i] = word i of in_block for i=0..15, set out_idx=0, and go to RUN next cycle.
- RUN:
  - in_ready=0; in_valid is ignored, and no block is queued.
  - out_valid=1; out_word=win[0] (registered, no combinational path from inputs); busy=1.
  - On out_valid&&out_ready (beat):
    - win[i] <= win[i+1] for i=0..14.
    - win[15] <= sig1(win[14]) + win[9] + sig0(win[1]) + win[0], mod 2^32 (carries above bit 31 discarded).
    - out_idx increments.
  - Without a beat, win, out_idx and out_word hold stable (AXI-style; value must not change while valid and not ready).
  - Beat with out_idx==NUM_ROUNDS-1: go to IDLE, out_valid=0, out_idx=0.
- sig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x). sig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). Rotates are 32-bit circular; shifts zero-fill.
- Latency: block accept in cycle N puts W0 on out_word in cycle N+1. With out_ready held high, one word per cycle and W63 in cycle N+64. Minimum 65 cycles per block.
- After the last beat there is one IDLE cycle before the next block can be accepted (in_ready rises the cycle after the last beat).
- Words 0..15 emitted are exactly the loaded words. Words 16+ come from the recurrence.
- Reset asserted mid-stream: immediate return to reset values; the partial block is discarded and no further words are emitted.
- out_last is a registered decode of out_idx and is never high when out_valid=0.

Test Plan:
- "abc" block (in_block = 0x61626380, then 14 zero words, then 0x00000018), out_ready=1 -> W0=0x61626380, W1..W14=0, W15=0x00000018, W16=0x61626380, W17=0x000F0000; out_last only at out_idx=63; in_ready=1 one cycle after the last beat.
- All-zero block -> 64 beats of out_word=0x00000000 with out_idx 0..63 in order, then IDLE.
- Backpressure: "abc" block, out_ready toggled pseudo-randomly (including 10-cycle low stretches at idx 15 and 63) -> out_word/out_idx held stable while stalled; the word sequence matches a reference model of the recurrence; exactly 64 beats.
- in_valid held high with a different block throughout RUN -> second block not accepted until IDLE; the first block's stream is uncorrupted; the second block starts W0 one cycle after acceptance.
- rst_n pulsed low at out_idx=30 -> out_valid=0, in_ready=1, out_idx=0 asynchronously; a new all-ones block then yields W0..W15=0xFFFFFFFF and W16 equal to the model value.
- Random blocks (≥1000) versus a software SHA-256 schedule model with random out_ready -> every W0..W63 matches bit-exactly.
